// File: rtl/arb_burst_pkg.sv
// Shared constants for the burst mux that sits behind the two-requester arbiter.
package arb_burst_pkg;

    // Default data width, beats per grant and burst counter width.
    localparam int DEF_DW    = 8;
    localparam int DEF_BURST = 4;
    localparam int DEF_CW    = 8;

    // FSM encoding. All four codes are in use; the default branch still routes to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_XFER0    = 2'd1,
        ST_XFER1    = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    // True when the counter has reached the last beat of a burst.
    function automatic logic is_last(input logic [DEF_CW-1:0] cnt, input int burst);
        return cnt == DEF_CW'(burst - 1);
    endfunction

endpackage

// File: rtl/arb_burst_mux_if.sv
// Bundle of grant, source and output-channel signals around arb_burst_mux.
interface arb_burst_mux_if
    import arb_burst_pkg::*;
#(
    parameter int DW = DEF_DW
);
    // grants from the arbiter
    logic          gnt0;
    logic          gnt1;
    // source 0 / source 1 streams
    logic [DW-1:0] din0;
    logic          vld0;
    logic          rdy0;
    logic [DW-1:0] din1;
    logic          vld1;
    logic          rdy1;
    // shared output channel
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          dout_rdy;
    // status
    logic          done0;
    logic          done1;
    logic          busy;
    logic          err;

    // The mux itself.
    modport slave (
        input  gnt0, gnt1, din0, vld0, din1, vld1, dout_rdy,
        output rdy0, rdy1, dout, dout_vld, done0, done1, busy, err
    );

    // Arbiter, sources and sink as seen from outside.
    modport master (
        output gnt0, gnt1, din0, vld0, din1, vld1, dout_rdy,
        input  rdy0, rdy1, dout, dout_vld, done0, done1, busy, err
    );

endinterface

// File: rtl/arb_out_reg.sv
// Single-entry registered output slot. Loads on accept, drains on sink ready,
// and reports whether a new beat can be taken this cycle.
module arb_out_reg
    import arb_burst_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] din,
    input  logic          dout_rdy,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          space
);

    // Slot is free when empty or when the held beat leaves this cycle.
    assign space = !dout_vld || dout_rdy;

    // Hold register: a load wins over a drain; dout keeps its last value when drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout     <= '0;
            dout_vld <= 1'b0;
        end else if (load) begin
            dout     <= din;
            dout_vld <= 1'b1;
        end else if (dout_vld && dout_rdy) begin
            dout_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/arb_burst_mux.sv
// Moves a fixed-length burst from the granted source onto one registered
// output channel, pulses done per source at burst end, and flags grant
// protocol violations from the upstream arbiter.
module arb_burst_mux
    import arb_burst_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int BURST = DEF_BURST,
    parameter int CW    = DEF_CW
) (
    input  logic           clk,
    input  logic           rst,
    arb_burst_mux_if.slave bus
);

    localparam logic [CW-1:0] LAST = CW'(BURST - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          done0_q;
    logic          done1_q;
    logic          err_q;
    logic          done0_nxt;
    logic          done1_nxt;
    logic          err_nxt;

    logic [1:0]    gnt;
    logic [1:0]    vld;
    logic [1:0]    rdy;
    logic [1:0]    acc;
    logic          space;
    logic          load;
    logic [DW-1:0] load_data;

    assign gnt = {bus.gnt1, bus.gnt0};
    assign vld = {bus.vld1, bus.vld0};

    // Ready needs the matching transfer state, a still-asserted grant (so a
    // grant drop blocks the accept in that same cycle) and a free output slot.
    assign rdy[0] = !rst && (state == ST_XFER0) && gnt[0] && space;
    assign rdy[1] = !rst && (state == ST_XFER1) && gnt[1] && space;
    assign acc    = vld & rdy;

    // At most one of acc[1:0] can be set, since only one XFER state is active.
    assign load      = |acc;
    assign load_data = acc[1] ? bus.din1 : bus.din0;

    arb_out_reg #(.DW(DW)) u_out (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .din      (load_data),
        .dout_rdy (bus.dout_rdy),
        .dout     (bus.dout),
        .dout_vld (bus.dout_vld),
        .space    (space)
    );

    // State, beat counter and registered status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            done0_q <= done0_nxt;
            done1_q <= done1_nxt;
            err_q   <= err_nxt;
        end
    end

    // Next-state, counter and pulse decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done0_nxt = 1'b0;
        done1_nxt = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (gnt[0] && gnt[1]) begin
                    err_nxt = 1'b1;
                end else if (gnt[0]) begin
                    state_nxt = ST_XFER0;
                end else if (gnt[1]) begin
                    state_nxt = ST_XFER1;
                end
            end
            ST_XFER0: begin
                if (!gnt[0]) begin
                    // grant pulled mid-burst: abandon it, no done
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b1;
                end else begin
                    // the other grant rising is reported but otherwise ignored
                    if (gnt[1]) err_nxt = 1'b1;
                    if (acc[0]) begin
                        if (cnt == LAST) begin
                            state_nxt = ST_WAIT_REL;
                            cnt_nxt   = '0;
                            done0_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
            end
            ST_XFER1: begin
                if (!gnt[1]) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b1;
                end else begin
                    if (gnt[0]) err_nxt = 1'b1;
                    if (acc[1]) begin
                        if (cnt == LAST) begin
                            state_nxt = ST_WAIT_REL;
                            cnt_nxt   = '0;
                            done1_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
            end
            ST_WAIT_REL: begin
                // arbiter drops its grant one cycle after the request falls;
                // never start a new burst straight from here
                if (!gnt[0] && !gnt[1]) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.rdy0  = rdy[0];
    assign bus.rdy1  = rdy[1];
    assign bus.done0 = done0_q;
    assign bus.done1 = done1_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_arb_burst_mux.sv
// Scoreboard bench for arb_burst_mux: directed bursts push expected beats,
// a negedge monitor pops and compares every beat the sink consumes.
module tb_arb_burst_mux;
    import arb_burst_pkg::*;

    localparam int DW    = 8;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arb_burst_mux_if #(.DW(DW)) bus ();

    arb_burst_mux #(.DW(DW), .BURST(BURST), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // grants come either from the directed sequence or from the arbiter model
    logic m_gnt0 = 1'b0, m_gnt1 = 1'b0;
    logic a_gnt0 = 1'b0, a_gnt1 = 1'b0;
    logic arb_mode = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0;
    assign bus.gnt0 = arb_mode ? a_gnt0 : m_gnt0;
    assign bus.gnt1 = arb_mode ? a_gnt1 : m_gnt1;

    logic [DW-1:0] src0_q[$];
    logic [DW-1:0] src1_q[$];
    logic [DW-1:0] exp_q[$];

    int tests = 0, fails = 0;
    int done0_cnt = 0, done1_cnt = 0, err_cnt = 0;
    int exp_done0 = 0, exp_done1 = 0, exp_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a beat is consumed when dout_vld & dout_rdy hold at the negedge.
    always @(negedge clk) begin
        if (bus.dout_vld && bus.dout_rdy) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL beat_unexpected: got 0x%0h expected none", bus.dout);
            end else begin
                chk("beat", {24'h0, bus.dout}, {24'h0, exp_q.pop_front()});
            end
        end
        if (bus.done0) done0_cnt++;
        if (bus.done1) done1_cnt++;
        if (bus.err)   err_cnt++;
    end

    // Sources and arbiter model: sample handshakes at negedge, update after posedge.
    initial begin
        logic a0, a1;
        logic last_g;
        last_g    = 1'b1;
        bus.vld0  = 1'b0;
        bus.vld1  = 1'b0;
        bus.din0  = '0;
        bus.din1  = '0;
        forever begin
            @(negedge clk);
            a0 = bus.vld0 && bus.rdy0;
            a1 = bus.vld1 && bus.rdy1;
            @(posedge clk);
            #1;
            if (a0 && src0_q.size() > 0) void'(src0_q.pop_front());
            if (a1 && src1_q.size() > 0) void'(src1_q.pop_front());
            if (arb_mode) begin
                if (a_gnt0) begin
                    if (!req0) a_gnt0 = 1'b0;
                end else if (a_gnt1) begin
                    if (!req1) a_gnt1 = 1'b0;
                end else if (req0 && (!req1 || last_g)) begin
                    a_gnt0 = 1'b1;
                    last_g = 1'b0;
                end else if (req1) begin
                    a_gnt1 = 1'b1;
                    last_g = 1'b1;
                end
            end
            bus.vld0 = src0_q.size() > 0;
            bus.din0 = (src0_q.size() > 0) ? src0_q[0] : '0;
            bus.vld1 = src1_q.size() > 0;
            bus.din1 = (src1_q.size() > 0) ? src1_q[0] : '0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // From a drive point: queue n beats on source s, expect the first nexp.
    task automatic load_src(input int s, input logic [DW-1:0] base, input int n, input int nexp);
        smp();
        #1;
        for (int i = 0; i < n; i++) begin
            if (s == 0) src0_q.push_back(base + DW'(i));
            else        src1_q.push_back(base + DW'(i));
            if (i < nexp) exp_q.push_back(base + DW'(i));
        end
        step();
    endtask

    // From a drive point: wait (bounded) for rdyN; returns at that negedge.
    task automatic wait_rdy(input int s, output int waited);
        logic found;
        found  = 1'b0;
        waited = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            smp();
            if ((s == 0) ? bus.rdy0 : bus.rdy1) found = 1'b1;
            else begin
                waited++;
                step();
            end
        end
        chk("wait_rdy", {31'h0, found}, 32'h1);
    endtask

    // From a drive point: wait (bounded) for doneN; returns at that negedge.
    task automatic wait_done(input int s);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            smp();
            if ((s == 0) ? bus.done0 : bus.done1) found = 1'b1;
            else step();
        end
        chk("wait_done", {31'h0, found}, 32'h1);
    endtask

    // Complete directed burst: grant, wait for done, release, check idle.
    task automatic run_burst(input int s, input logic [DW-1:0] base);
        load_src(s, base, BURST, BURST);
        if (s == 0) begin exp_done0++; m_gnt0 = 1'b1; end
        else        begin exp_done1++; m_gnt1 = 1'b1; end
        step();
        wait_done(s);
        step();
        m_gnt0 = 1'b0;
        m_gnt1 = 1'b0;
        step();
        smp();
        chk("burst_busy_released", {31'h0, bus.busy}, 32'h0);
        step();
    endtask

    initial begin
        int w;
        int issued;
        logic r0_was, r1_was;
        bus.dout_rdy = 1'b1;

        // reset state, with a grant already asserted
        m_gnt0 = 1'b1;
        smp();
        chk("rst_dout_vld", {31'h0, bus.dout_vld}, 32'h0);
        chk("rst_dout", {24'h0, bus.dout}, 32'h0);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_rdy0", {31'h0, bus.rdy0}, 32'h0);
        chk("rst_pulses", {29'h0, bus.done0, bus.done1, bus.err}, 32'h0);
        step();
        m_gnt0 = 1'b0;
        rst    = 1'b0;
        step();

        // burst 0: 0x10..0x13, full throughput
        load_src(0, 8'h10, BURST, BURST);
        exp_done0++;
        m_gnt0 = 1'b1;
        smp();
        chk("t1_rdy0_idle", {31'h0, bus.rdy0}, 32'h0);
        step();
        wait_rdy(0, w);
        chk("t1_rdy_latency", w, 0);
        for (int i = 0; i < BURST; i++) begin
            step();
            smp();
            chk("t1_dout_vld", {31'h0, bus.dout_vld}, 32'h1);
            chk("t1_dout", {24'h0, bus.dout}, 32'h10 + i);
        end
        chk("t1_done0", {31'h0, bus.done0}, 32'h1);
        chk("t1_rdy0_wait_rel", {31'h0, bus.rdy0}, 32'h0);
        chk("t1_busy_wait_rel", {31'h0, bus.busy}, 32'h1);
        step();
        m_gnt0 = 1'b0;
        smp();
        chk("t1_busy_release", {31'h0, bus.busy}, 32'h1);
        chk("t1_done0_single", {31'h0, bus.done0}, 32'h0);
        chk("t1_drained", {31'h0, bus.dout_vld}, 32'h0);
        step();
        smp();
        chk("t1_busy_idle", {31'h0, bus.busy}, 32'h0);
        step();

        // burst 1 with sink stall on burst cycles 2-4
        load_src(1, 8'h20, BURST, BURST);
        exp_done1++;
        m_gnt1 = 1'b1;
        step();
        wait_rdy(1, w);
        for (int i = 0; i < 3; i++) begin
            step();
            bus.dout_rdy = 1'b0;
            smp();
            chk("t2_rdy1_stall", {31'h0, bus.rdy1}, 32'h0);
            chk("t2_dout_hold", {24'h0, bus.dout}, 32'h20);
            chk("t2_dout_vld_hold", {31'h0, bus.dout_vld}, 32'h1);
        end
        step();
        bus.dout_rdy = 1'b1;
        smp();
        chk("t2_rdy1_resume", {31'h0, bus.rdy1}, 32'h1);
        step();
        wait_done(1);
        step();
        m_gnt1 = 1'b0;
        step();
        smp();
        chk("t2_busy_idle", {31'h0, bus.busy}, 32'h0);
        step();

        // both grants from IDLE
        m_gnt0 = 1'b1;
        m_gnt1 = 1'b1;
        exp_err++;
        smp();
        chk("t3_rdy_both", {30'h0, bus.rdy1, bus.rdy0}, 32'h0);
        chk("t3_err_before", {31'h0, bus.err}, 32'h0);
        step();
        m_gnt0 = 1'b0;
        m_gnt1 = 1'b0;
        smp();
        chk("t3_err", {31'h0, bus.err}, 32'h1);
        chk("t3_busy", {31'h0, bus.busy}, 32'h0);
        step();
        smp();
        chk("t3_err_one_cycle", {31'h0, bus.err}, 32'h0);
        step();

        // grant 0 dropped after two accepted beats
        load_src(0, 8'h30, BURST, 2);
        m_gnt0 = 1'b1;
        exp_err++;
        step();
        wait_rdy(0, w);
        step();
        smp();
        chk("t4_rdy0_second", {31'h0, bus.rdy0}, 32'h1);
        step();
        m_gnt0 = 1'b0;
        smp();
        chk("t4_rdy0_gated", {31'h0, bus.rdy0}, 32'h0);
        chk("t4_dout_second", {24'h0, bus.dout}, 32'h31);
        chk("t4_dout_vld", {31'h0, bus.dout_vld}, 32'h1);
        step();
        smp();
        chk("t4_err", {31'h0, bus.err}, 32'h1);
        chk("t4_busy", {31'h0, bus.busy}, 32'h0);
        chk("t4_no_done0", {31'h0, bus.done0}, 32'h0);
        src0_q.delete();
        step();
        run_burst(1, 8'h40);

        // reset during the third beat of a gnt1 burst
        load_src(1, 8'h60, BURST, BURST);
        m_gnt1 = 1'b1;
        step();
        wait_rdy(1, w);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("t5_async_vld", {31'h0, bus.dout_vld}, 32'h0);
        chk("t5_async_busy", {31'h0, bus.busy}, 32'h0);
        smp();
        chk("t5_rdy1_rst", {31'h0, bus.rdy1}, 32'h0);
        exp_q.delete();
        src1_q.delete();
        step();
        m_gnt1 = 1'b0;
        rst    = 1'b0;
        step();
        run_burst(0, 8'h70);

        // 20 alternating bursts through the arbiter model
        arb_mode = 1'b1;
        issued   = 0;
        for (int c = 0; c < 3000; c++) begin
            smp();
            #1;
            if (issued == 20 && exp_q.size() == 0 && !req0 && !req1 && !bus.busy) break;
            r0_was = req0;
            r1_was = req1;
            if (bus.done0) req0 = 1'b0;
            if (bus.done1) req1 = 1'b0;
            if (issued < 20 && ((issued % 2 == 0) ? !r0_was : !r1_was)) begin
                for (int i = 0; i < BURST; i++) begin
                    if (issued % 2 == 0) src0_q.push_back(DW'(issued * 4 + i));
                    else                 src1_q.push_back(DW'(issued * 4 + i));
                    exp_q.push_back(DW'(issued * 4 + i));
                end
                if (issued % 2 == 0) begin req0 = 1'b1; exp_done0++; end
                else                 begin req1 = 1'b1; exp_done1++; end
                issued++;
            end
        end
        chk("t6_issued", issued, 20);
        chk("t6_drained", exp_q.size(), 0);
        chk("t6_idle", {31'h0, bus.busy}, 32'h0);

        chk("done0_count", done0_cnt, exp_done0);
        chk("done1_count", done1_cnt, exp_done1);
        chk("err_count", err_cnt, exp_err);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop if anything wedges.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
